// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared types and sizing for the sequential 32-bit adder
package add_seq_pkg;
  localparam int W_SLICE = 8;
  localparam int N_BEATS = 4;
  localparam int BEAT_W = $clog2(N_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/add32_seq_ctrl_rca.sv
// RCA_8bit: 8-bit ripple-carry adder slice
module RCA_8bit
  import add_seq_pkg::*;
(
  input  logic [W_SLICE-1:0] a,
  input  logic [W_SLICE-1:0] b,
  input  logic               cin,
  output logic [W_SLICE-1:0] sum,
  output logic               cout
);
  logic [W_SLICE:0] c;
  assign c[0] = cin;
  assign cout = c[W_SLICE];
  for (genvar i = 0; i < W_SLICE; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
endmodule

// File: rtl/add32_seq_ctrl.sv
// add32_seq_ctrl: 32-bit add/sub computed one byte per beat through a shared 8-bit slice
module add32_seq_ctrl
  import add_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);
  state_t state, state_n;
  logic [BEAT_W-1:0] beat;
  logic c;
  logic [31:0] a_r, b_r;
  logic [W_SLICE-1:0] s;
  logic co, accept;
  logic [4:0] base;
  assign base = {beat, 3'b000};
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign accept = in_valid && in_ready;
  RCA_8bit u_slice (
    .a    (a_r[base +: W_SLICE]),
    .b    (b_r[base +: W_SLICE]),
    .cin  (c),
    .sum  (s),
    .cout (co)
  );
  // Next state: BUSY runs to the last beat; DONE may hand off straight into a new op
  always_comb begin
    state_n = state;
    if (state == BUSY) state_n = (beat == LAST_BEAT) ? DONE : BUSY;
    else if (accept) state_n = BUSY;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  // State, operand latch and per-beat write-back of the slice result
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      c     <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_r  <= a;
        b_r  <= b ^ {32{sub}};
        c    <= cin ^ sub;
        beat <= '0;
      end else if (state == BUSY) begin
        sum[base +: W_SLICE] <= s;
        c    <= co;
        beat <= beat + 1'b1;
        if (beat == LAST_BEAT) begin
          cout <= co;
          ovf  <= (a_r[31] == b_r[31]) && (s[W_SLICE-1] != a_r[31]);
        end
      end
    end
  end
endmodule

// File: tb/tb_add32_seq_ctrl.sv
// tb_add32_seq_ctrl: directed self-checking bench for add32_seq_ctrl
module tb_add32_seq_ctrl;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, cin = 0, sub = 0;
  logic out_valid, out_ready = 1, cout, ovf;
  logic [31:0] a = 0, b = 0, sum;
  int n_checks = 0, n_fail = 0;

  add32_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic start(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, input logic ts);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if ({sum, cout, ovf} !== 34'd0) begin n_fail++; $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b want 0", sum, cout, ovf); end
    a = 32'h55; b = 32'h66; in_valid = 1;
    @(negedge clk);
    rst = 0; in_valid = 0;
    repeat (6) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_vs_valid got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_add_carry;
    int n;
    start(32'h0000_00FF, 32'h0000_0001, 0, 0);
    wait_done(n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL add_latency got %0d want 4", n); end
    n_checks++; if ({sum, cout, ovf} !== {32'h0000_0100, 2'b00}) begin n_fail++; $display("FAIL add_carry got sum=%h cout=%b ovf=%b want 00000100/0/0", sum, cout, ovf); end
    @(negedge clk);
  endtask

  task automatic test_full_ripple;
    int n;
    start(32'hFFFF_FFFF, 32'h0, 1, 0);
    wait_done(n);
    n_checks++; if ({sum, cout, ovf} !== {32'h0, 2'b10}) begin n_fail++; $display("FAIL full_ripple got sum=%h cout=%b ovf=%b want 00000000/1/0", sum, cout, ovf); end
    @(negedge clk);
  endtask

  task automatic test_subtract;
    int n;
    start(32'd5, 32'd7, 0, 1);
    wait_done(n);
    n_checks++; if ({sum, cout, ovf} !== {32'hFFFF_FFFE, 2'b00}) begin n_fail++; $display("FAIL sub_neg got sum=%h cout=%b ovf=%b want fffffffe/0/0", sum, cout, ovf); end
    @(negedge clk);
    start(32'h8000_0000, 32'd1, 0, 1);
    wait_done(n);
    n_checks++; if ({sum, cout, ovf} !== {32'h7FFF_FFFF, 2'b11}) begin n_fail++; $display("FAIL sub_ovf got sum=%h cout=%b ovf=%b want 7fffffff/1/1", sum, cout, ovf); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n;
    out_ready = 0;
    start(32'h1234_5678, 32'h1111_1111, 0, 0);
    wait_done(n);
    a = 32'd1; b = 32'd2; cin = 0; sub = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({out_valid, in_ready, sum, cout, ovf} !== {2'b10, 32'h2345_6789, 2'b00}) begin n_fail++; $display("FAIL hold_%0d got ov=%b ir=%b sum=%h cout=%b ovf=%b want 1/0/23456789/0/0", i, out_valid, in_ready, sum, cout, ovf); end
    end
    out_ready = 1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got out_valid=%b want 0", out_valid); end
    wait_done(n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL b2b_latency got %0d want 4", n); end
    n_checks++; if (sum !== 32'd3) begin n_fail++; $display("FAIL b2b_sum got %h want 00000003", sum); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int n;
    start(32'hAAAA_AAAA, 32'h5555_5555, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_checks++; if ({out_valid, in_ready, sum, cout, ovf} !== {2'b01, 34'd0}) begin n_fail++; $display("FAIL abort got ov=%b ir=%b sum=%h cout=%b ovf=%b want 0/1/0/0/0", out_valid, in_ready, sum, cout, ovf); end
    start(32'd10, 32'd20, 0, 0);
    wait_done(n);
    n_checks++; if ({n[7:0], sum, cout, ovf} !== {8'd4, 32'd30, 2'b00}) begin n_fail++; $display("FAIL after_abort got n=%0d sum=%h cout=%b ovf=%b want 4/0000001e/0/0", n, sum, cout, ovf); end
    @(negedge clk);
  endtask

  task automatic test_ignored_input;
    int n, extra;
    start(32'h0000_1000, 32'h0000_0234, 0, 0);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1; in_valid = 1;
    repeat (2) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready got %b want 0", in_ready); end
      @(negedge clk);
    end
    in_valid = 0; sub = 0;
    wait_done(n);
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL ignored_latency got %0d want 2", n); end
    n_checks++; if (sum !== 32'h0000_1234) begin n_fail++; $display("FAIL ignored_sum got %h want 00001234", sum); end
    @(negedge clk);
    extra = 0;
    repeat (6) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL extra_result got %0d want 0", extra); end
  endtask

  initial begin
    test_reset;
    test_add_carry;
    test_full_ripple;
    test_subtract;
    test_back_to_back;
    test_reset_mid_op;
    test_ignored_input;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
